// File: rtl/ptw_model_pkg.sv
// ptw_model_pkg: shared widths, PTE permission bit positions and walker FSM states
// for the behavioural PTW responder.
package ptw_model_pkg;

    localparam int VPN_W  = 27;
    localparam int PPN_W  = 54;
    localparam int PERM_W = 8;

    localparam int PERM_V = 0;
    localparam int PERM_R = 1;
    localparam int PERM_W_BIT = 2;
    localparam int PERM_X = 3;
    localparam int PERM_U = 4;
    localparam int PERM_G = 5;
    localparam int PERM_A = 6;
    localparam int PERM_D = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/ptw_lookup_table.sv
// ptw_lookup_table: bench-programmed VPN->PTE table with a combinational
// lowest-index-wins match against a single lookup VPN.
module ptw_lookup_table
    import ptw_model_pkg::*;
#(
    parameter  int NENTRIES = 8,
    localparam int IDX_W    = $clog2(NENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [VPN_W-1:0]  wr_vpn_i,
    input  logic [PPN_W-1:0]  wr_ppn_i,
    input  logic [PERM_W-1:0] wr_perm_i,
    input  logic [VPN_W-1:0]  lookup_vpn_i,
    output logic              hit_o,
    output logic [PPN_W-1:0]  ppn_o,
    output logic [PERM_W-1:0] perm_o
);

    logic [VPN_W-1:0]  vpn_q  [NENTRIES];
    logic [PPN_W-1:0]  ppn_q  [NENTRIES];
    logic [PERM_W-1:0] perm_q [NENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENTRIES; i++) begin
                vpn_q[i]  <= '0;
                ppn_q[i]  <= '0;
                perm_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            vpn_q[wr_idx_i]  <= wr_vpn_i;
            ppn_q[wr_idx_i]  <= wr_ppn_i;
            perm_q[wr_idx_i] <= wr_perm_i;
        end
    end

    // Scan high to low so the lowest matching index is the last one to assign.
    always_comb begin
        hit_o  = 1'b0;
        ppn_o  = '0;
        perm_o = '0;
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if (perm_q[i][PERM_V] && vpn_q[i] == lookup_vpn_i) begin
                hit_o  = 1'b1;
                ppn_o  = ppn_q[i];
                perm_o = perm_q[i];
            end
        end
    end

endmodule

// File: rtl/ptw_responder_model.sv
// ptw_responder_model: PTW side of the req/resp interface; answers one request at a
// time with a table-derived PTE after a fixed latency, with hit/miss statistics.
module ptw_responder_model
    import ptw_model_pkg::*;
#(
    parameter  int               NENTRIES     = 8,
    parameter  int               LATENCY      = 4,
    parameter  logic [VPN_W-1:0] AE_VPN_LIMIT = 27'h4000000,
    localparam int               IDX_W        = $clog2(NENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              req_ready,
    input  logic              req_valid,
    input  logic [VPN_W-1:0]  req_bits_addr,
    output logic              resp_valid,
    output logic              resp_bits_ae,
    output logic [PPN_W-1:0]  resp_bits_pte_ppn,
    output logic [PERM_W-1:0] resp_bits_pte_dagux_wrv,
    input  logic              tbl_wr_en,
    input  logic [IDX_W-1:0]  tbl_wr_idx,
    input  logic [VPN_W-1:0]  tbl_wr_vpn,
    input  logic [PPN_W-1:0]  tbl_wr_ppn,
    input  logic [PERM_W-1:0] tbl_wr_perm,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [VPN_W-1:0]  vpn_q;
    logic              ae_q;
    logic [PPN_W-1:0]  ppn_q;
    logic [PERM_W-1:0] perm_q;
    logic [31:0]       hit_q, miss_q;

    logic              accept, enter_resp, ae, pte_v, tbl_hit;
    logic [VPN_W-1:0]  lookup_vpn;
    logic [PPN_W-1:0]  tbl_ppn;
    logic [PERM_W-1:0] tbl_perm;

    assign accept     = req_valid && state_q == IDLE;
    // With LATENCY==1 the lookup edge is the accept edge, so look at the live address.
    assign lookup_vpn = state_q == IDLE ? req_bits_addr : vpn_q;
    assign enter_resp = state_d == RESP;
    assign ae         = lookup_vpn >= AE_VPN_LIMIT;
    assign pte_v      = !ae && tbl_hit;

    ptw_lookup_table #(.NENTRIES(NENTRIES)) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (tbl_wr_en),
        .wr_idx_i     (tbl_wr_idx),
        .wr_vpn_i     (tbl_wr_vpn),
        .wr_ppn_i     (tbl_wr_ppn),
        .wr_perm_i    (tbl_wr_perm),
        .lookup_vpn_i (lookup_vpn),
        .hit_o        (tbl_hit),
        .ppn_o        (tbl_ppn),
        .perm_o       (tbl_perm)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE;
                cnt_d   = accept ? CNT_INIT : cnt_q;
            end
            WAIT: begin
                state_d = cnt_q == 8'd1 ? RESP : WAIT;
                cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vpn_q   <= '0;
            ae_q    <= 1'b0;
            ppn_q   <= '0;
            perm_q  <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept)
                vpn_q <= req_bits_addr;
            if (enter_resp) begin
                ae_q   <= ae;
                ppn_q  <= pte_v ? tbl_ppn : '0;
                perm_q <= pte_v ? tbl_perm : '0;
                if (pte_v)
                    hit_q <= hit_q + {31'd0, hit_q != '1};
                else
                    miss_q <= miss_q + {31'd0, miss_q != '1};
            end
        end
    end

    assign req_ready               = state_q == IDLE;
    assign resp_valid              = state_q == RESP;
    assign resp_bits_ae            = ae_q;
    assign resp_bits_pte_ppn       = ppn_q;
    assign resp_bits_pte_dagux_wrv = perm_q;
    assign hit_count               = hit_q;
    assign miss_count              = miss_q;

endmodule

// File: tb/tb_ptw_responder_model.sv
// tb_ptw_responder_model: scoreboard bench; a table/counter reference model predicts
// each response at accept time and a negedge monitor compares DUT responses.
module tb_ptw_responder_model;

    localparam int          LAT   = 4;
    localparam logic [26:0] AE_LIM = 27'h4000000;

    typedef struct {
        logic        ae;
        logic [53:0] ppn;
        logic [7:0]  perm;
        logic [31:0] hits;
        logic [31:0] misses;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_valid1 = 1'b0;
    logic [26:0] req_addr = '0, req_addr1 = '0;
    logic        tbl_wr_en = 1'b0;
    logic [2:0]  tbl_wr_idx = '0;
    logic [26:0] tbl_wr_vpn = '0;
    logic [53:0] tbl_wr_ppn = '0;
    logic [7:0]  tbl_wr_perm = '0;

    logic        req_ready, resp_valid, resp_ae;
    logic [53:0] resp_ppn;
    logic [7:0]  resp_perm;
    logic [31:0] hit_count, miss_count;
    logic        req_ready1, resp_valid1, resp_ae1;
    logic [53:0] resp_ppn1;
    logic [7:0]  resp_perm1;
    logic [31:0] hit_count1, miss_count1;

    int checks = 0, passed = 0, cyc = 0;
    exp_t exp_q[$];
    logic [26:0] m_vpn [8];
    logic [53:0] m_ppn [8];
    logic [7:0]  m_perm [8];
    logic [31:0] m_hits = 0, m_misses = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ptw_responder_model #(.NENTRIES(8), .LATENCY(LAT), .AE_VPN_LIMIT(AE_LIM)) dut (
        .clk(clk), .rst_n(rst_n), .req_ready(req_ready), .req_valid(req_valid),
        .req_bits_addr(req_addr), .resp_valid(resp_valid), .resp_bits_ae(resp_ae),
        .resp_bits_pte_ppn(resp_ppn), .resp_bits_pte_dagux_wrv(resp_perm),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_vpn(tbl_wr_vpn),
        .tbl_wr_ppn(tbl_wr_ppn), .tbl_wr_perm(tbl_wr_perm),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    ptw_responder_model #(.NENTRIES(8), .LATENCY(1), .AE_VPN_LIMIT(AE_LIM)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_ready(req_ready1), .req_valid(req_valid1),
        .req_bits_addr(req_addr1), .resp_valid(resp_valid1), .resp_bits_ae(resp_ae1),
        .resp_bits_pte_ppn(resp_ppn1), .resp_bits_pte_dagux_wrv(resp_perm1),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_vpn(tbl_wr_vpn),
        .tbl_wr_ppn(tbl_wr_ppn), .tbl_wr_perm(tbl_wr_perm),
        .hit_count(hit_count1), .miss_count(miss_count1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want)
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        else
            passed++;
    endtask

    function automatic exp_t predict(input logic [26:0] vpn);
        exp_t e = '{ae: 1'b0, ppn: '0, perm: '0, hits: '0, misses: '0, due: 0};
        if (vpn >= AE_LIM) begin
            e.ae = 1'b1;
            return e;
        end
        for (int i = 0; i < 8; i++)
            if (m_perm[i][0] && m_vpn[i] == vpn) begin
                e.ppn  = m_ppn[i];
                e.perm = m_perm[i];
                return e;
            end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_vpn[i] = '0; m_ppn[i] = '0; m_perm[i] = '0;
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("req_ready", req_ready, exp_q.size() == 0);
        if (resp_valid) begin
            if (exp_q.size() == 0)
                chk("spurious_resp", resp_valid, 1'b0);
            else begin
                e = exp_q.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(e.due));
                chk("resp_ae", resp_ae, e.ae);
                chk("resp_ppn", resp_ppn, e.ppn);
                chk("resp_perm", resp_perm, e.perm);
                chk("hit_count", hit_count, e.hits);
                chk("miss_count", miss_count, e.misses);
            end
        end else if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
            chk("resp_missing", resp_valid, 1'b1);
            void'(exp_q.pop_front());
        end
    end

    task automatic wr(input int idx, input logic [26:0] vpn, input logic [53:0] ppn, input logic [7:0] perm);
        @(negedge clk);
        tbl_wr_en = 1'b1; tbl_wr_idx = 3'(idx); tbl_wr_vpn = vpn; tbl_wr_ppn = ppn; tbl_wr_perm = perm;
        @(negedge clk);
        tbl_wr_en = 1'b0;
        m_vpn[idx] = vpn; m_ppn[idx] = ppn; m_perm[idx] = perm;
    endtask

    task automatic do_req(input logic [26:0] vpn, input bit hold, output int acc);
        exp_t e;
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = vpn;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_accept_timeout", req_ready, 1'b1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        @(posedge clk);
        e = predict(vpn);
        if (e.perm[0]) m_hits++; else m_misses++;
        e.hits = m_hits;
        e.misses = m_misses;
        e.due = acc + LAT;
        exp_q.push_back(e);
        if (!hold) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        int a, a2, nresp;
        logic [26:0] pool [4];
        logic [63:0] r64;
        exp_t e;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        chk("rst_resp_ppn", resp_ppn, 54'd0);

        wr(2, 27'h00123, 54'h4567, 8'b1100_1011);
        do_req(27'h00123, 1'b0, a);
        drain();
        repeat (3) @(negedge clk);
        chk("resp_held_ppn", resp_ppn, 54'h4567);

        do_req(27'h00999, 1'b0, a);
        do_req(27'h3FFFFFF, 1'b0, a);
        do_req(27'h4000000, 1'b0, a);
        do_req(27'h7FFFFFF, 1'b0, a);
        drain();

        wr(5, 27'h0ABCD, 54'h2_0000_0000_AAAA, 8'h0F);
        wr(1, 27'h0ABCD, 54'h3_FFFF_0000_1111, 8'hC7);
        do_req(27'h0ABCD, 1'b0, a);
        drain();

        // Rewrite idx1 so the write lands on the lookup edge of an in-flight request.
        do_req(27'h0ABCD, 1'b0, a);
        while (cyc < a + LAT - 1) @(negedge clk);
        tbl_wr_en = 1'b1; tbl_wr_idx = 3'd1; tbl_wr_vpn = 27'h0ABCD;
        tbl_wr_ppn = 54'h0_1234_5678_9ABC; tbl_wr_perm = 8'h03;
        @(negedge clk);
        tbl_wr_en = 1'b0;
        m_vpn[1] = 27'h0ABCD; m_ppn[1] = 54'h0_1234_5678_9ABC; m_perm[1] = 8'h03;
        drain();
        do_req(27'h0ABCD, 1'b0, a);
        drain();

        e = predict(27'h0ABCD);
        @(negedge clk);
        chk("lat1_ready", req_ready1, 1'b1);
        req_valid1 = 1'b1;
        req_addr1 = 27'h0ABCD;
        @(negedge clk);
        req_valid1 = 1'b0;
        chk("lat1_resp_valid", resp_valid1, 1'b1);
        chk("lat1_resp_ppn", resp_ppn1, e.ppn);
        chk("lat1_resp_perm", resp_perm1, e.perm);
        @(negedge clk);
        chk("lat1_resp_single", resp_valid1, 1'b0);
        chk("lat1_ready_back", req_ready1, 1'b1);

        do_req(27'h00123, 1'b1, a);
        do_req(27'h00123, 1'b0, a2);
        chk("held_reaccept_gap", 64'(a2 - a), 64'(LAT + 1));
        drain();

        do_req(27'h00123, 1'b0, a);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        nresp = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            nresp += int'(resp_valid);
        end
        chk("abort_no_resp", 64'(nresp), 64'd0);
        chk("abort_hit_count", hit_count, 32'd0);
        chk("abort_miss_count", miss_count, 32'd0);
        do_req(27'h00123, 1'b0, a);
        drain();

        for (int i = 0; i < 4; i++)
            pool[i] = i == 0 ? 27'h00123 : 27'($urandom_range(0, 32'h3FFFFFF));
        for (int it = 0; it < 80; it++) begin
            int unsigned r = $urandom_range(0, 9);
            if (r < 3) begin
                drain();
                r64 = {$urandom(), $urandom()};
                wr(int'($urandom_range(0, 7)), pool[$urandom_range(0, 3)], r64[53:0], 8'($urandom()));
            end else begin
                int unsigned s = $urandom_range(0, 6);
                logic [26:0] v;
                v = s < 4 ? pool[s] : s == 4 ? 27'h3FFFFFF : 27'(AE_LIM + 27'($urandom_range(0, 1000)));
                if ($urandom_range(0, 3) == 0) begin
                    do_req(v, 1'b1, a);
                    do_req(v, 1'b0, a2);
                    chk("rand_held_gap", 64'(a2 - a), 64'(LAT + 1));
                end else
                    do_req(v, 1'b0, a);
            end
        end
        drain();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
